// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_ctrl_pkg
// Brief  : Shared definitions for the pipeline hazard controller: stage
//          indices, stall/flush vector constants, FSM state encoding and the
//          stall-priority helper.
// Rev    : 1.0  initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

  // Stage bit positions inside stalled[5:0] / flush[5:0]
  localparam int STG_PC = 0;
  localparam int STG_WB = 5;

  // Thermometer stall vectors, one per requester
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  // Flush vectors
  localparam logic [5:0] FLUSH_NONE = 6'b000000;
  localparam logic [5:0] FLUSH_BR   = 6'b000110;  // kill IF/ID and ID/EX
  localparam logic [5:0] FLUSH_TRAP = 6'b011110;  // kill IF..MEM

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PEND_BR = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_TRAP    = 2'd3
  } state_t;

  // Deepest requesting stage wins; the result is always a thermometer code.
  function automatic logic [5:0] stall_vec(input logic req_mem, input logic req_ex,
                                           input logic req_id, input logic req_if);
    if (req_mem)     return STALL_MEM;
    else if (req_ex) return STALL_EX;
    else if (req_id) return STALL_ID;
    else if (req_if) return STALL_IF;
    else             return STALL_NONE;
  endfunction

endpackage : pipe_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module : pipe_perf_cnt
// Brief  : Saturating event counter for pipeline performance statistics.
//          The module only exists when PIPE_CTRL_PERF_EN is defined, so a
//          default build carries no counter logic at all.
// Ports  : clk  in  core clock
//          rst  in  async reset, active-low
//          inc  in  count this cycle
//          cnt  out PERF_W current count, sticks at all-ones
// Macro  : PIPE_CTRL_PERF_EN
// Rev    : 1.0  initial release
// ============================================================================
`ifdef PIPE_CTRL_PERF_EN
module pipe_perf_cnt #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [PERF_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {PERF_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule : pipe_perf_cnt
`endif
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_ctrl
// Brief  : Central pipeline controller. Produces the per-stage stall/flush
//          vectors and the PC redirect. Arbitrates stage stall requests, EX
//          branch redirects and trap entry; keeps a branch redirect pending
//          while fetch is blocked and drains MEM before entering a trap.
// Ports  : clk               in   core clock
//          rst               in   async reset, active-low
//          stallreq_if/id/ex/mem in stage stall requests
//          ex_branch_flag_i  in   EX resolved taken branch
//          ex_branch_addr_i  in   branch target
//          excp_req_i        in   trap request (level until trap_ack_o)
//          excp_addr_i       in   trap vector
//          stalled/flush     out  per-stage vectors (combinational)
//          new_pc_o          out  redirect target
//          new_pc_valid_o    out  PC loads new_pc_o this edge
//          trap_ack_o        out  trap redirect issued (pulse)
//          drain_timeout_o   out  trap forced after DRAIN_MAX (pulse)
//          stall_cnt_o       out  cycles with PC stalled
//          flush_cnt_o       out  redirects issued
// Macro  : PIPE_CTRL_PERF_EN enables the saturating performance counters;
//          without it both counter outputs are tied to zero.
// Rev    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int DRAIN_MAX = 16,
  parameter int PERF_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              ex_branch_flag_i,
  input  logic [31:0]       ex_branch_addr_i,
  input  logic              excp_req_i,
  input  logic [31:0]       excp_addr_i,
  output logic [5:0]        stalled,
  output logic [5:0]        flush,
  output logic [31:0]       new_pc_o,
  output logic              new_pc_valid_o,
  output logic              trap_ack_o,
  output logic              drain_timeout_o,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
);

  import pipe_hazard_ctrl_pkg::*;

  localparam int DW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);

  state_t        state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_cnt_nxt;
  logic [31:0]   pend_addr, pend_addr_nxt;

  logic [5:0]    stalled_c, flush_c, base_stall;
  logic [31:0]   new_pc_c;
  logic          valid_c, ack_c, timeout_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
      pend_addr <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      pend_addr <= pend_addr_nxt;
    end
  end

  always_comb begin
    base_stall    = stall_vec(stallreq_mem, stallreq_ex, stallreq_id, stallreq_if);
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    pend_addr_nxt = pend_addr;
    stalled_c     = base_stall;
    flush_c       = FLUSH_NONE;
    new_pc_c      = '0;
    valid_c       = 1'b0;
    ack_c         = 1'b0;
    timeout_c     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (excp_req_i) begin
          // Trap beats any branch in the same cycle; freeze fetch only.
          stalled_c = STALL_IF;
          state_nxt = stallreq_mem ? ST_DRAIN : ST_TRAP;
        end else if (ex_branch_flag_i && !stallreq_ex && !stallreq_mem) begin
          flush_c  = FLUSH_BR;
          new_pc_c = ex_branch_addr_i;
          if (!stallreq_if) begin
            valid_c = 1'b1;
          end else begin
            // Fetch cannot accept the redirect now; keep the target.
            pend_addr_nxt = ex_branch_addr_i;
            state_nxt     = ST_PEND_BR;
          end
        end
        // A branch blocked by EX/MEM is simply re-presented by EX later.
      end

      ST_PEND_BR: begin
        stalled_c = STALL_IF;
        if (excp_req_i) begin
          pend_addr_nxt = '0;
          state_nxt     = stallreq_mem ? ST_DRAIN : ST_TRAP;
        end else begin
          flush_c  = FLUSH_BR;
          new_pc_c = pend_addr;
          if (!stallreq_if) begin
            valid_c       = 1'b1;
            pend_addr_nxt = '0;
            state_nxt     = ST_IDLE;
          end
        end
      end

      ST_DRAIN: begin
        stalled_c = STALL_MEM;
        if (!stallreq_mem || (drain_cnt == DRAIN_LAST)) begin
          // Timeout is reported only when MEM is still busy at the limit.
          timeout_c     = stallreq_mem;
          drain_cnt_nxt = '0;
          state_nxt     = ST_TRAP;
        end else begin
          drain_cnt_nxt = drain_cnt + 1'b1;
        end
      end

      ST_TRAP: begin
        stalled_c = STALL_NONE;
        flush_c   = FLUSH_TRAP;
        new_pc_c  = excp_addr_i;
        valid_c   = 1'b1;
        ack_c     = 1'b1;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are forced quiet while reset is held.
  always_comb begin
    stalled         = rst ? stalled_c : '0;
    flush           = rst ? flush_c   : '0;
    new_pc_o        = rst ? new_pc_c  : '0;
    new_pc_valid_o  = rst & valid_c;
    trap_ack_o      = rst & ack_c;
    drain_timeout_o = rst & timeout_c;
  end

`ifdef PIPE_CTRL_PERF_EN
  pipe_perf_cnt #(
    .PERF_W (PERF_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stalled[STG_PC]),
    .cnt (stall_cnt_o)
  );

  pipe_perf_cnt #(
    .PERF_W (PERF_W)
  ) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (new_pc_valid_o),
    .cnt (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_hazard_ctrl
// Brief  : Self-checking bench for pipe_hazard_ctrl. A table of per-cycle
//          input/expected-output records is applied in a loop; expected
//          values are queued when a row is driven and popped on the falling
//          edge when the outputs are sampled.
// Macro  : PIPE_CTRL_PERF_EN selects the expected performance counter values.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int DRAIN_MAX = 16;
  localparam int PERF_W    = 32;
  localparam logic [31:0] BR_ADDR = 32'h0000_0100;
  localparam logic [31:0] EX_ADDR = 32'h8000_0040;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              stallreq_if = 1'b0, stallreq_id = 1'b0;
  logic              stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic              ex_branch_flag_i = 1'b0, excp_req_i = 1'b0;
  logic [31:0]       ex_branch_addr_i = BR_ADDR;
  logic [31:0]       excp_addr_i = EX_ADDR;
  logic [5:0]        stalled, flush;
  logic [31:0]       new_pc_o;
  logic              new_pc_valid_o, trap_ack_o, drain_timeout_o;
  logic [PERF_W-1:0] stall_cnt_o, flush_cnt_o;

  pipe_hazard_ctrl #(
    .DRAIN_MAX (DRAIN_MAX),
    .PERF_W    (PERF_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_if      (stallreq_if),
    .stallreq_id      (stallreq_id),
    .stallreq_ex      (stallreq_ex),
    .stallreq_mem     (stallreq_mem),
    .ex_branch_flag_i (ex_branch_flag_i),
    .ex_branch_addr_i (ex_branch_addr_i),
    .excp_req_i       (excp_req_i),
    .excp_addr_i      (excp_addr_i),
    .stalled          (stalled),
    .flush            (flush),
    .new_pc_o         (new_pc_o),
    .new_pc_valid_o   (new_pc_valid_o),
    .trap_ack_o       (trap_ack_o),
    .drain_timeout_o  (drain_timeout_o),
    .stall_cnt_o      (stall_cnt_o),
    .flush_cnt_o      (flush_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  st;
    logic [5:0]  fl;
    logic [31:0] pc;
    logic        v;
    logic        ack;
    logic        tmo;
  } exp_t;

  typedef struct {
    string name;
    logic  rstn, sif, sid, sex, smem, br, excp;
    exp_t  e;
  } vec_t;

  vec_t  tbl[$];
  exp_t  sb[$];
  string sb_name[$];

  int checks = 0;
  int passed = 0;
  longint exp_stall = 0;
  longint exp_flush = 0;

  // inp = {rstn, if, id, ex, mem, br, excp}
  function automatic void add(input string name, input logic [6:0] inp,
                              input logic [5:0] st, input logic [5:0] fl,
                              input logic [31:0] pc, input logic v,
                              input logic ack, input logic tmo);
    vec_t r;
    r.name = name;
    {r.rstn, r.sif, r.sid, r.sex, r.smem, r.br, r.excp} = inp;
    r.e = '{st: st, fl: fl, pc: pc, v: v, ack: ack, tmo: tmo};
    tbl.push_back(r);
  endfunction

  task automatic step(input vec_t r);
    exp_t got, exp;
    string nm;
    @(posedge clk);
    #1;
    rst              = r.rstn;
    stallreq_if      = r.sif;
    stallreq_id      = r.sid;
    stallreq_ex      = r.sex;
    stallreq_mem     = r.smem;
    ex_branch_flag_i = r.br;
    excp_req_i       = r.excp;
    sb.push_back(r.e);
    sb_name.push_back(r.name);
    @(negedge clk);
    got = '{st: stalled, fl: flush, pc: new_pc_o, v: new_pc_valid_o,
            ack: trap_ack_o, tmo: drain_timeout_o};
    exp = sb.pop_front();
    nm  = sb_name.pop_front();
    checks++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got st=%b fl=%b pc=%h v=%b ack=%b tmo=%b, want st=%b fl=%b pc=%h v=%b ack=%b tmo=%b",
               nm, got.st, got.fl, got.pc, got.v, got.ack, got.tmo,
               exp.st, exp.fl, exp.pc, exp.v, exp.ack, exp.tmo);
    end
    if (!r.rstn) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      exp_stall += longint'(exp.st[0]);
      exp_flush += longint'(exp.v);
    end
  endtask

  task automatic check_cnt(input string name, input logic [PERF_W-1:0] got,
                           input logic [PERF_W-1:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0d want %0d", name, got, want);
  endtask

  initial begin
    // ------------------------------------------------ single-cycle table
    //                          rifxmbe
    add("rst_hold",        7'b0111111, 6'b000000, 6'b000000, 32'h0,   0, 0, 0);
    add("idle",            7'b1000000, 6'b000000, 6'b000000, 32'h0,   0, 0, 0);
    add("id_only",         7'b1010000, 6'b000111, 6'b000000, 32'h0,   0, 0, 0);
    add("if_only",         7'b1100000, 6'b000011, 6'b000000, 32'h0,   0, 0, 0);
    add("ex_over_if",      7'b1101000, 6'b001111, 6'b000000, 32'h0,   0, 0, 0);
    add("mem_over_all",    7'b1111100, 6'b011111, 6'b000000, 32'h0,   0, 0, 0);
    add("br_now",          7'b1000010, 6'b000000, 6'b000110, BR_ADDR, 1, 0, 0);
    add("br_ex_busy",      7'b1001010, 6'b001111, 6'b000000, 32'h0,   0, 0, 0);
    add("br_mem_busy",     7'b1000110, 6'b011111, 6'b000000, 32'h0,   0, 0, 0);
    add("br_with_id",      7'b1010010, 6'b000111, 6'b000110, BR_ADDR, 1, 0, 0);
    // ------------------------------------------------ branch held pending
    add("pend_c1",         7'b1100010, 6'b000011, 6'b000110, BR_ADDR, 0, 0, 0);
    add("pend_c2",         7'b1100000, 6'b000011, 6'b000110, BR_ADDR, 0, 0, 0);
    add("pend_c3",         7'b1100000, 6'b000011, 6'b000110, BR_ADDR, 0, 0, 0);
    add("pend_issue",      7'b1000000, 6'b000011, 6'b000110, BR_ADDR, 1, 0, 0);
    add("pend_done",       7'b1000000, 6'b000000, 6'b000000, 32'h0,   0, 0, 0);
    // ------------------------------------------------ 5-cycle drain
    add("drain_dec",       7'b1000101, 6'b000011, 6'b000000, 32'h0,   0, 0, 0);
    for (int i = 0; i < 4; i++)
      add("drain_busy",    7'b1000101, 6'b011111, 6'b000000, 32'h0,   0, 0, 0);
    add("drain_clear",     7'b1000001, 6'b011111, 6'b000000, 32'h0,   0, 0, 0);
    add("drain_trap",      7'b1000001, 6'b000000, 6'b011110, EX_ADDR, 1, 1, 0);
    add("drain_after",     7'b1000000, 6'b000000, 6'b000000, 32'h0,   0, 0, 0);
    // ------------------------------------------------ branch and trap together
    add("br_excp",         7'b1000011, 6'b000011, 6'b000000, 32'h0,   0, 0, 0);
    add("br_excp_trap",    7'b1000001, 6'b000000, 6'b011110, EX_ADDR, 1, 1, 0);
    add("br_excp_after",   7'b1000000, 6'b000000, 6'b000000, 32'h0,   0, 0, 0);
    // ------------------------------------------------ trap during pending branch
    add("pexc_pend",       7'b1100010, 6'b000011, 6'b000110, BR_ADDR, 0, 0, 0);
    add("pexc_excp",       7'b1100001, 6'b000011, 6'b000000, 32'h0,   0, 0, 0);
    add("pexc_trap",       7'b1000001, 6'b000000, 6'b011110, EX_ADDR, 1, 1, 0);
    add("pexc_after",      7'b1000000, 6'b000000, 6'b000000, 32'h0,   0, 0, 0);
    // ------------------------------------------------ drain timeout
    add("tmo_dec",         7'b1000101, 6'b000011, 6'b000000, 32'h0,   0, 0, 0);
    for (int i = 1; i < DRAIN_MAX; i++)
      add("tmo_wait",      7'b1000101, 6'b011111, 6'b000000, 32'h0,   0, 0, 0);
    add("tmo_pulse",       7'b1000101, 6'b011111, 6'b000000, 32'h0,   0, 0, 1);
    add("tmo_trap",        7'b1000101, 6'b000000, 6'b011110, EX_ADDR, 1, 1, 0);
    add("tmo_after",       7'b1000000, 6'b000000, 6'b000000, 32'h0,   0, 0, 0);
    // ------------------------------------------------ reset mid-drain
    add("rd_dec",          7'b1000101, 6'b000011, 6'b000000, 32'h0,   0, 0, 0);
    add("rd_drain1",       7'b1000101, 6'b011111, 6'b000000, 32'h0,   0, 0, 0);
    add("rd_drain2",       7'b1000101, 6'b011111, 6'b000000, 32'h0,   0, 0, 0);
    add("rd_reset",        7'b0000101, 6'b000000, 6'b000000, 32'h0,   0, 0, 0);
    add("rd_release",      7'b1000000, 6'b000000, 6'b000000, 32'h0,   0, 0, 0);
    add("rd_idle_id",      7'b1010000, 6'b000111, 6'b000000, 32'h0,   0, 0, 0);
    add("rd_br",           7'b1000010, 6'b000000, 6'b000110, BR_ADDR, 1, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
    end

    // Counters are sampled after the last row's edge has been taken.
    @(posedge clk);
    #1;
`ifdef PIPE_CTRL_PERF_EN
    check_cnt("stall_cnt", stall_cnt_o, PERF_W'(exp_stall));
    check_cnt("flush_cnt", flush_cnt_o, PERF_W'(exp_flush));
`else
    check_cnt("stall_cnt_off", stall_cnt_o, '0);
    check_cnt("flush_cnt_off", flush_cnt_o, '0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
